imem_loader: RTL

//   Boot-time instruction-memory writer for the single-cycle MIPS core.

---
 rtl/imem_loader_if.sv | 28 ++
 rtl/imem_loader.sv | 117 +++++++++++
 2 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream, instruction-memory write and status signals of the boot loader.
// The slave modport is the loader; the master modport is the host/bench side.
interface imem_loader_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic [ADDR_W:0]   num_words;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_rst_n;
  logic              busy;
  logic              done;
  logic              err;

  modport slave (
    input  start, num_words, in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata, cpu_rst_n, busy, done, err
  );

  modport master (
    output start, num_words, in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata, cpu_rst_n, busy, done, err
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction-memory writer: assembles a byte stream into words,
// writes them out, verifies an XOR checksum and only then releases the core.
module imem_loader #(
  parameter int ADDR_W     = 8,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  imem_loader_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_RECV, S_WRITE, S_CHKSUM, S_DONE, S_ERR
  } state_e;

  localparam logic [ADDR_W:0] CAP = (ADDR_W+1)'(1) << ADDR_W;

  state_e            state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [1:0]        bc_q, bc_d;
  logic [7:0]        xor_q, xor_d;
  logic [31:0]       word_q, word_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;

  logic        in_ready;
  logic        accept;
  logic        bad_cnt;
  logic        last_word;
  logic [31:0] nxt_word;

  assign in_ready  = (state_q == S_RECV) || (state_q == S_CHKSUM);
  assign accept    = bus.in_valid && in_ready;
  assign bad_cnt   = (bus.num_words == '0) || (bus.num_words > CAP);
  assign last_word = ({1'b0, idx_q} == (cnt_q - (ADDR_W+1)'(1)));
  // Shift direction decides byte placement; after four bytes the word is complete either way.
  assign nxt_word  = BIG_ENDIAN ? {word_q[23:0], bus.in_data}
                                : {bus.in_data, word_q[31:8]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      bc_q    <= '0;
      xor_q   <= '0;
      word_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      bc_q    <= bc_d;
      xor_q   <= xor_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    bc_d    = bc_q;
    xor_d   = xor_q;
    word_d  = word_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (bus.start) begin
          if (bad_cnt) begin
            state_d = S_ERR;
          end else begin
            state_d = S_RECV;
            cnt_d   = bus.num_words;
            idx_d   = '0;
            bc_d    = '0;
            xor_d   = '0;
          end
        end
      end
      S_RECV: begin
        if (accept) begin
          word_d = nxt_word;
          xor_d  = xor_q ^ bus.in_data;
          bc_d   = bc_q + 2'd1;
          // Output registers load here so the write strobe lands one cycle after the 4th byte.
          if (bc_q == 2'd3) begin
            state_d = S_WRITE;
            addr_d  = idx_q;
            wdata_d = nxt_word;
          end
        end
      end
      S_WRITE: begin
        idx_d   = idx_q + 1'b1;
        state_d = last_word ? S_CHKSUM : S_RECV;
      end
      S_CHKSUM: begin
        if (accept) state_d = (bus.in_data == xor_q) ? S_DONE : S_ERR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.in_ready  = in_ready;
  assign bus.mem_we    = (state_q == S_WRITE);
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.cpu_rst_n = (state_q == S_DONE);
  assign bus.busy      = (state_q == S_RECV) || (state_q == S_WRITE) || (state_q == S_CHKSUM);
  assign bus.done      = (state_q == S_DONE);
  assign bus.err       = (state_q == S_ERR);
endmodule
